req_timeout_ctrl: RTL and testbench
===================================

REQ_TIMEOUT_CTRL -- requirements
Module: req_timeout_ctrl

Interface
REQ-001 Parameter MAX_RETRY, default 3: retries after the first attempt before failure (range 0..3).
REQ-002 Parameter SHORT_TO, default 20: attempt window in cycles when long_to=0 (range 2..63).
REQ-003 Parameter LONG_TO, default 40: attempt window in cycles when long_to=1 (range 2..63).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  begin transaction; honoured only in IDLE.
REQ-007 long_to  input  1  window select, sampled only on an accepted start.
REQ-008 ack  input  1  partner response; honoured only in REQ state.
REQ-009 clr_err  input  1  clears sticky err (see Configuration).
REQ-010 req  output  1  request to partner, high throughout REQ state.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle success pulse.
REQ-013 fail  output  1  one-cycle pulse when retries are exhausted.
REQ-014 retry_cnt  output  2  retries consumed in the current or last transaction.
REQ-015 err  output  1  sticky failure flag.

Function
REQ-016 States SHALL be IDLE, REQ and GAP; every output SHALL be registered.
REQ-017 IDLE plus start SHALL: move to REQ next cycle; latch window (long_to ? LONG_TO : SHORT_TO); clear 6-bit cycle counter and retry_cnt.
REQ-018 In REQ, req=1 and the counter SHALL increment each cycle from 0.
REQ-019 ack in REQ SHALL cause IDLE next cycle, with done=1 for that one cycle and req=0.
REQ-020 At counter==window-1 with ack=0: if retry_cnt<MAX_RETRY, go to GAP and increment retry_cnt; otherwise go to IDLE with fail=1 for one cycle.
REQ-021 Result: req stays high for exactly window cycles per unanswered attempt.
REQ-022 ack in the same cycle as counter==window-1 SHALL count as success; success takes priority over timeout.
REQ-023 GAP SHALL last exactly one cycle with req=0, then enter REQ with counter=0.
REQ-024 start outside IDLE SHALL be ignored, and the latched window SHALL remain unchanged.
REQ-025 ack in IDLE or GAP SHALL be ignored.
REQ-026 done and fail SHALL never assert in the same cycle.
REQ-027 retry_cnt SHALL hold its value in IDLE until the next accepted start.
REQ-028 start in the cycle immediately after a done/fail pulse SHALL be accepted.

Reset
REQ-029 rst=1 SHALL immediately force IDLE with req=0, busy=0, done=0, fail=0, retry_cnt=0, err=0 and counter=0, including mid-transaction.
REQ-030 After rst deasserts, the block SHALL accept start on the first clock edge.

Configuration
REQ-031 With macro REQ_TIMEOUT_STICKY_ERR_EN defined, err SHALL set in the same cycle fail asserts and remain high until clr_err=1 clears it next cycle.
REQ-032 With REQ_TIMEOUT_STICKY_ERR_EN defined, a fail in the same cycle as clr_err SHALL win, leaving err=1.
REQ-033 Without REQ_TIMEOUT_STICKY_ERR_EN, err SHALL be constant 0, clr_err SHALL be ignored, and all other behaviour SHALL be identical.

Verification
REQ-034 Bench SHALL cover: long_to=0, start, ack on 5th req cycle -> done pulse 1 cycle later, retry_cnt=0, req high 5 cycles.
REQ-035 Bench SHALL cover: long_to=1, no ack -> req high 40 cycles, 1-cycle gaps, four attempts, then fail pulse, retry_cnt=3, err=1 if REQ_TIMEOUT_STICKY_ERR_EN is defined.
REQ-036 Bench SHALL cover: long_to=0, ack on cycle 20 of the second attempt (boundary) -> done, not GAP; retry_cnt=1.
REQ-037 Bench SHALL cover: start and long_to toggled during REQ -> ignored, window stays 20.
REQ-038 Bench SHALL cover: rst asserted on cycle 10 of an attempt -> req, busy and retry_cnt are 0 asynchronously; the next start runs a full window.
REQ-039 Bench SHALL cover: err=1, then clr_err=1 together with a new failing transaction's fail -> err remains 1; a later clr_err alone -> err=0.

Source files
------------

// File: rtl/req_timeout_ctrl.sv
// Request/ack handshake with a per-attempt timeout window, one-cycle gap between retries and bounded retry count.
// All outputs registered; optional sticky failure flag enabled by macro REQ_TIMEOUT_STICKY_ERR_EN.
module req_timeout_ctrl #(
  parameter int MAX_RETRY = 3,
  parameter int SHORT_TO  = 20,
  parameter int LONG_TO   = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       long_to,
  input  logic       ack,
  input  logic       clr_err,
  output logic       req,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [1:0] retry_cnt,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [5:0] SHORT_W = 6'(SHORT_TO);
  localparam logic [5:0] LONG_W  = 6'(LONG_TO);
  localparam logic [1:0] MAX_R   = 2'(MAX_RETRY);

  state_t     state, state_nxt;
  logic [5:0] cnt, cnt_nxt;
  logic [5:0] win, win_nxt;
  logic [1:0] retry_nxt;
  logic       done_nxt, fail_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    win_nxt   = win;
    retry_nxt = retry_cnt;
    done_nxt  = 1'b0;
    fail_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = REQ;
          win_nxt   = long_to ? LONG_W : SHORT_W;
          cnt_nxt   = 6'd0;
          retry_nxt = 2'd0;
        end
      end
      REQ: begin
        // an ack on the last window cycle still counts as success
        if (ack) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else if (cnt == win - 6'd1) begin
          cnt_nxt = 6'd0;
          if (retry_cnt < MAX_R) begin
            state_nxt = GAP;
            retry_nxt = retry_cnt + 2'd1;
          end else begin
            state_nxt = IDLE;
            fail_nxt  = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 6'd1;
        end
      end
      GAP: begin
        state_nxt = REQ;
        cnt_nxt   = 6'd0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 6'd0;
      win       <= SHORT_W;
      retry_cnt <= 2'd0;
      done      <= 1'b0;
      fail      <= 1'b0;
      req       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      win       <= win_nxt;
      retry_cnt <= retry_nxt;
      done      <= done_nxt;
      fail      <= fail_nxt;
      req       <= (state_nxt == REQ);
      busy      <= (state_nxt != IDLE);
    end
  end

`ifdef REQ_TIMEOUT_STICKY_ERR_EN
  // a new failure wins over a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err <= 1'b0;
    else if (fail_nxt)
      err <= 1'b1;
    else if (clr_err)
      err <= 1'b0;
  end
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_req_timeout_ctrl.sv
// Bench for req_timeout_ctrl: directed scenarios plus randomized traffic against a transaction-timeline model.
module tb_req_timeout_ctrl;

  localparam int MAX_RETRY = 3;
  localparam int SHORT_TO  = 20;
  localparam int LONG_TO   = 40;
`ifdef REQ_TIMEOUT_STICKY_ERR_EN
  localparam logic [31:0] STICKY = 32'd1;
`else
  localparam logic [31:0] STICKY = 32'd0;
`endif

  logic       clk = 1'b0;
  logic       rst, start, long_to, ack, clr_err;
  logic       req, busy, done, fail, err;
  logic [1:0] retry_cnt;

  req_timeout_ctrl #(
    .MAX_RETRY(MAX_RETRY),
    .SHORT_TO (SHORT_TO),
    .LONG_TO  (LONG_TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .long_to  (long_to),
    .ack      (ack),
    .clr_err  (clr_err),
    .req      (req),
    .busy     (busy),
    .done     (done),
    .fail     (fail),
    .retry_cnt(retry_cnt),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: t = cycles elapsed since the transaction entered its first request.
  // Each attempt occupies win request cycles followed by one gap cycle.
  bit m_act, m_done, m_fail, m_err;
  int m_t, m_win, m_retry;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d, want %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic bit m_req();
    return m_act && ((m_t % (m_win + 1)) < m_win);
  endfunction

  function automatic int m_rcnt();
    return m_act ? (m_t + 1) / (m_win + 1) : m_retry;
  endfunction

  function automatic bit m_fail_due();
    return m_act && ((m_t % (m_win + 1)) == m_win - 1) && ((m_t / (m_win + 1)) == MAX_RETRY);
  endfunction

  task automatic m_reset();
    m_act = 0; m_done = 0; m_fail = 0; m_err = 0;
    m_t = 0; m_win = SHORT_TO; m_retry = 0;
  endtask

  task automatic m_step();
    int p, a;
    m_done = 0;
    m_fail = 0;
    if (!m_act) begin
      if (start) begin
        m_act = 1; m_t = 0; m_retry = 0;
        m_win = long_to ? LONG_TO : SHORT_TO;
      end
    end else begin
      p = m_t % (m_win + 1);
      a = m_t / (m_win + 1);
      if (p < m_win && ack) begin
        m_done = 1; m_act = 0; m_retry = a;
      end else if (p == m_win - 1 && a == MAX_RETRY) begin
        m_fail = 1; m_act = 0; m_retry = a;
      end else begin
        m_t++;
      end
    end
    if (STICKY != 0) begin
      if (m_fail) m_err = 1;
      else if (clr_err) m_err = 0;
    end
  endtask

  task automatic check_all();
    chk("cyc.req",       32'(req),       32'(m_req()));
    chk("cyc.busy",      32'(busy),      32'(m_act));
    chk("cyc.done",      32'(done),      32'(m_done));
    chk("cyc.fail",      32'(fail),      32'(m_fail));
    chk("cyc.retry_cnt", 32'(retry_cnt), 32'(m_rcnt()));
    chk("cyc.err",       32'(err),       32'(m_err));
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("arst.req",   32'(req),       0);
    chk("arst.busy",  32'(busy),      0);
    chk("arst.retry", 32'(retry_cnt), 0);
    chk("arst.done",  32'(done),      0);
    chk("arst.fail",  32'(fail),      0);
    chk("arst.err",   32'(err),       0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int nreq, ngap, rate;
    bit seen;
    rst = 1'b1; start = 1'b0; long_to = 1'b0; ack = 1'b0; clr_err = 1'b0;
    m_reset();
    #3;
    chk("reset.req",   32'(req),       0);
    chk("reset.busy",  32'(busy),      0);
    chk("reset.done",  32'(done),      0);
    chk("reset.fail",  32'(fail),      0);
    chk("reset.retry", 32'(retry_cnt), 0);
    chk("reset.err",   32'(err),       0);
    @(negedge clk);
    rst = 1'b0;

    // short window, ack on the fifth request cycle; start on first edge after reset
    start = 1'b1; long_to = 1'b0;
    tick();
    start = 1'b0;
    chk("s1.accept", 32'(busy), 1);
    nreq = int'(req);
    repeat (4) begin tick(); nreq += int'(req); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("s1.req_cycles", nreq, 5);
    chk("s1.done",  32'(done),      1);
    chk("s1.req",   32'(req),       0);
    chk("s1.retry", 32'(retry_cnt), 0);
    tick();
    chk("s1.done_width", 32'(done), 0);

    // long window, never acked: four attempts then fail
    long_to = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    nreq = 0; ngap = 0; seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (req) nreq++;
      if (busy && !req) ngap++;
      tick();
      if (fail) seen = 1;
    end
    chk("s2.fail_seen", 32'(seen), 1);
    chk("s2.req_cycles", nreq, 160);
    chk("s2.gaps", ngap, 3);
    chk("s2.retry", 32'(retry_cnt), 3);
    chk("s2.err", 32'(err), STICKY);

    // start right after the fail pulse; ack on the last cycle of attempt two
    long_to = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("s3.accept", 32'(busy), 1);
    repeat (19) tick();
    chk("s3.req_last", 32'(req), 1);
    tick();
    chk("s3.gap", 32'(req), 0);
    tick();
    chk("s3.retry1", 32'(retry_cnt), 1);
    repeat (19) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("s3.done",  32'(done),      1);
    chk("s3.busy",  32'(busy),      0);
    chk("s3.retry", 32'(retry_cnt), 1);
    tick();
    chk("s3.no_gap", 32'(busy), 0);

    // start/long_to toggled during REQ must not restart or resize the window
    start = 1'b1; long_to = 1'b0;
    tick();
    nreq = 0;
    for (int i = 0; i < 100 && req; i++) begin
      nreq++;
      start = 1'($urandom % 2);
      long_to = 1'b1;
      tick();
    end
    start = 1'b0;
    chk("s4.window", nreq, 20);
    chk("s4.in_gap", 32'(busy), 1);
    ack = 1'b1;
    tick();
    chk("s4.ack_gap_ignored", 32'(req), 1);
    tick();
    ack = 1'b0;
    chk("s4.done", 32'(done), 1);

    // async reset on cycle 10 of the second attempt
    start = 1'b1; long_to = 1'b0;
    tick();
    start = 1'b0;
    repeat (21) tick();
    repeat (9) tick();
    chk("s5.retry_pre", 32'(retry_cnt), 1);
    chk("s5.req_pre",   32'(req),       1);
    async_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    nreq = 0;
    for (int i = 0; i < 100 && req; i++) begin nreq++; tick(); end
    chk("s5.full_window", nreq, 20);
    ack = 1'b1;
    repeat (2) tick();
    ack = 1'b0;

    // sticky err: fail beats a simultaneous clear, a lone clear drops it
    long_to = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 200 && !fail; i++) tick();
    chk("s6.err_set", 32'(err), STICKY);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 200 && !fail; i++) begin
      clr_err = m_fail_due();
      tick();
    end
    chk("s6.fail_with_clr", 32'(fail), 1);
    chk("s6.err_kept", 32'(err), STICKY);
    clr_err = 1'b0;
    tick();
    chk("s6.err_hold", 32'(err), STICKY);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("s6.err_cleared", 32'(err), 0);

    // randomized traffic, alternating frequent and rare acks
    for (int i = 0; i < 4000; i++) begin
      rate = ((i / 500) % 2 != 0) ? 50 : 5;
      start   = 1'(($urandom % 4) == 0);
      long_to = 1'($urandom % 2);
      ack     = 1'(($urandom % rate) == 0);
      clr_err = 1'(($urandom % 12) == 0);
      if (($urandom % 500) == 0) async_reset();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
